// File: rtl/waffle_pkg.sv
// Shared types and helpers for the waffle (max-sum subrectangle) stream solver.
//  data_t     : default-width signed element/accumulator type
//  state_t    : solver FSM states
//  npairs     : number of column-boundary pairs (j<k, j,k in 0..cols)
//  pair_index : flat index of pair (j,k), k-major so it needs no column count
//  max2       : signed maximum on data_t
package waffle_pkg;

  localparam int DATA_W_DEF = 32;

  typedef logic signed [DATA_W_DEF-1:0] data_t;

  typedef enum logic [1:0] {IDLE, ACCUM, REDUCE, DONE} state_t;

  function automatic int npairs(input int cols);
    return cols * (cols + 1) / 2;
  endfunction

  // Pairs are laid out k = 1..cols, j = 0..k-1, so index = k*(k-1)/2 + j.
  function automatic int pair_index(input int j, input int k);
    return (k * (k - 1)) / 2 + j;
  endfunction

  function automatic data_t max2(input data_t a, input data_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/waffle_stream_solver_if.sv
// Row-in / result-out handshake bundle for the waffle stream solver.
//  in_row/in_valid/in_last/in_ready : one image row per beat, in_last closes the frame
//  result/out_valid/out_ready       : signed maximum rectangle sum of the frame
//  slave  : solver side, master : row source / result sink side
interface waffle_stream_solver_if #(
  parameter int IMG_COLS = 4,
  parameter int DATA_W   = 32
);
  logic [IMG_COLS*DATA_W-1:0] in_row;
  logic                       in_valid;
  logic                       in_last;
  logic                       in_ready;
  logic [DATA_W-1:0]          result;
  logic                       out_valid;
  logic                       out_ready;

  modport slave (
    input  in_row, in_valid, in_last, out_ready,
    output in_ready, result, out_valid
  );

  modport master (
    output in_row, in_valid, in_last, out_ready,
    input  in_ready, result, out_valid
  );
endinterface

// File: rtl/waffle_pair_kadane.sv
// One Kadane cell for a single column-boundary pair.
//  clock, reset : clock and synchronous active-high reset
//  d            : this row's sum over the pair's column span
//  first        : treat the stored state as zero (first row of a frame)
//  row_fire     : a row is being accepted this cycle
//  clear        : zero the cell (frame result consumed)
//  best         : best run sum seen so far in this frame (never below 0)
module waffle_pair_kadane #(
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] d,
  input  logic                     first,
  input  logic                     row_fire,
  input  logic                     clear,
  output logic signed [DATA_W-1:0] best
);

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic signed [DATA_W-1:0] cur_q, cur_d;
  logic signed [DATA_W-1:0] best_q, best_d;
  logic signed [DATA_W-1:0] base_cur, base_best, ext_sum, cand;

  always_comb begin
    base_cur  = first ? '0 : cur_q;
    base_best = first ? '0 : best_q;
    // Wrapping add: overflow is allowed to go negative, the max keeps best intact.
    ext_sum   = base_cur + d;
    cand      = smax(ext_sum, d);
    cur_d     = cur_q;
    best_d    = best_q;
    if (clear) begin
      cur_d  = '0;
      best_d = '0;
    end else if (row_fire) begin
      cur_d  = cand;
      best_d = smax(base_best, cand);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_q  <= '0;
      best_q <= '0;
    end else begin
      cur_q  <= cur_d;
      best_q <= best_d;
    end
  end

  assign best = best_q;

endmodule

// File: rtl/waffle_stream_solver.sv
// Streaming max-sum-subrectangle solver.
//  clock, reset : clock and synchronous active-high reset
//  bus (slave)  : rows in (in_row/in_valid/in_last/in_ready),
//                 result out (result/out_valid/out_ready)
// Each accepted row updates a Kadane cell per column-boundary pair in parallel;
// after the last row the per-pair bests are scanned one per cycle into result.
module waffle_stream_solver
  import waffle_pkg::*;
#(
  parameter int IMG_COLS = 4,
  parameter int DATA_W   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  waffle_stream_solver_if.slave bus
);

  localparam int NPAIRS = npairs(IMG_COLS);
  localparam int IDX_W  = $clog2(NPAIRS + 1);

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic signed [DATA_W-1:0] result_q, result_d;

  logic                     in_ready, row_fire, out_fire, first;
  logic signed [DATA_W-1:0] prefix [IMG_COLS+1];
  logic signed [DATA_W-1:0] pair_d [NPAIRS];
  logic signed [DATA_W-1:0] best_w [NPAIRS];
  logic signed [DATA_W-1:0] scan_val;

  assign in_ready = !reset && (state_q == IDLE || state_q == ACCUM);
  assign row_fire = bus.in_valid && in_ready;
  assign out_fire = (state_q == DONE) && bus.out_ready;
  assign first    = (state_q == IDLE);

  // Row prefix sums: span (j,k) sums columns j..k-1.
  always_comb begin
    prefix[0] = '0;
    for (int c = 0; c < IMG_COLS; c++) begin
      prefix[c+1] = prefix[c] + $signed(bus.in_row[c*DATA_W +: DATA_W]);
    end
  end

  for (genvar k = 1; k <= IMG_COLS; k++) begin : g_k
    for (genvar j = 0; j < k; j++) begin : g_j
      localparam int P = pair_index(j, k);
      assign pair_d[P] = prefix[k] - prefix[j];
      waffle_pair_kadane #(.DATA_W(DATA_W)) u_cell (
        .clock    (clock),
        .reset    (reset),
        .d        (pair_d[P]),
        .first    (first),
        .row_fire (row_fire),
        .clear    (out_fire),
        .best     (best_w[P])
      );
    end
  end

  // Scan mux; idx == NPAIRS is the closing cycle and selects nothing.
  always_comb begin
    scan_val = '0;
    for (int i = 0; i < NPAIRS; i++) begin
      if (idx_q == IDX_W'(i)) scan_val = best_w[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (row_fire) begin
          if (bus.in_last) begin
            state_d = REDUCE;
            idx_d   = '0;
            acc_d   = '0;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      REDUCE: begin
        if (idx_q == IDX_W'(NPAIRS)) begin
          result_d = acc_q;
          state_d  = DONE;
        end else begin
          acc_d = smax(acc_q, scan_val);
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register boundary
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;

endmodule
